seg7_scan_driver: RTL and testbench
===================================

# seg7_scan_driver

Time-multiplexed driver for a common-anode multi-digit seven-segment display. It scans the digits one at a time, decodes each 4-bit value to hexadecimal glyphs, and drives the shared segment lines and per-digit anodes. Timed blanking gaps between digits prevent ghosting. New display contents load atomically at frame boundaries. It sits between the lab datapath (counters, ALU results) and the board's seven-segment pins.

## Interface
- `N_DIGITS`, default 8: number of digits scanned; legal range 1..16.
- `REFRESH_DIV`, default 100000: clock cycles per digit slot; must be ≥ `BLANK_CYCLES`+2.
- `BLANK_CYCLES`, default 1000: cycles at the start of each slot during which all anodes are off.
- Clock and reset: one clock; reset is asynchronous and active-high.
- `clk` in 1: system clock; all state changes on its rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `digits` in 4·`N_DIGITS`: hex value per digit; digit i is `digits[4i+3:4i]`.
- `dp_in` in `N_DIGITS`: decimal point request per digit, 1 = lit.
- `digit_en` in `N_DIGITS`: 1 = digit shown; 0 = digit blanked (its anode stays off).
- `load` in 1: single-cycle strobe that captures `digits`, `dp_in` and `digit_en`.
- `seg` out 7: active-low cathodes, ordered {g,f,e,d,c,b,a}.
- `DP` out 1: active-low decimal point.
- `AN` out `N_DIGITS`: active-low anodes; at most one bit is 0 at any time.
- `frame_start` out 1: one-cycle pulse when the scan index returns to digit 0.
- `pending` out 1: 1 while a captured load waits for the next frame boundary.

## Operation
- **Slot counter.** `cnt` runs 0..`REFRESH_DIV`-1.
  - At `REFRESH_DIV`-1, `cnt` returns to 0 and `idx` advances.
  - `idx` wraps from `N_DIGITS`-1 to 0.
- **Shadow registers.** Two banks, `pend_*` and `disp_*`, each holding digits, dp and en.
- **Load capture.** `load` captures the inputs into `pend_*` and sets `pending`=1.
  - A second `load` before the boundary overwrites `pend_*`; last value wins.
- **Frame boundary.** The boundary is the cycle with `cnt`=`REFRESH_DIV`-1 and `idx`=`N_DIGITS`-1.
  - If `pending`=1, then `disp_*` ← `pend_*` and `pending` ← 0.
- **Load on the boundary cycle.** The inputs go directly into `disp_*`. `pend_*` is also updated, and `pending` stays 0.
- **Blanking phase.** While `cnt` < `BLANK_CYCLES`, `AN` is all 1s.
- **Display phase.** Otherwise, `AN[idx]` = ~`disp_en[idx]` and all other `AN` bits are 1.
  - `seg` = decode(`disp_digits[idx]`).
  - `DP` = ~(`disp_dp[idx]` & `disp_en[idx]`).
  - When `disp_en[idx]`=0, `seg` = 7'h7F.
- **Decode table (active-low {g..a}).**
  - 0 = 40, 1 = 79, 2 = 24, 3 = 30
  - 4 = 19, 5 = 12, 6 = 02, 7 = 78
  - 8 = 00, 9 = 10, A = 08, b = 03
  - C = 46, d = 21, E = 06, F = 0E
- **`frame_start`.** Asserted in the cycle after the boundary, i.e. when `idx`=0 and `cnt`=0.
- **Widths.**
  - `cnt` is $clog2(`REFRESH_DIV`) bits.
  - `idx` is $clog2(`N_DIGITS`) bits, minimum 1.
  - `idx` never takes values ≥ `N_DIGITS`.

## Timing
- **Reset values (asynchronous, immediate).**
  - `AN` = all 1s, `seg` = 7'h7F, `DP` = 1.
  - `frame_start` = 0, `pending` = 0.
  - `cnt` = 0, `idx` = 0.
  - `disp_en` = 0 and `pend_en` = 0; `disp_digits`, `pend_digits`, `disp_dp`, `pend_dp` = 0.
- **Output registers.** `seg`, `DP`, `AN` and `frame_start` are registered. The value in cycle k reflects `cnt`, `idx` and `disp_*` of cycle k-1.
- **Slot and frame length.** A slot is exactly `REFRESH_DIV` cycles; a frame is `N_DIGITS`·`REFRESH_DIV` cycles.
- **Load latency.** `pending` rises the cycle after `load`. The new data is visible on the outputs from digit 0's display phase of the next frame, never mid-frame.
- **Reset mid-operation.** Outputs go dark immediately, the loaded data is discarded, and scanning restarts at digit 0 on the first edge after `rst` falls.
- **Single-digit build.** With `N_DIGITS`=1, every slot end is a frame boundary and `frame_start` pulses every `REFRESH_DIV` cycles.

## Test plan
All scenarios use `N_DIGITS`=8, `REFRESH_DIV`=4 and `BLANK_CYCLES`=1.
- **Reset.** Assert `rst` mid-slot → outputs immediately show `AN`=FF, `seg`=7F, `DP`=1, `pending`=0. After release, `frame_start` pulses once every 32 cycles.
- **Scan order.** Load `digits`=32'h76543210, `digit_en`=FF, `dp_in`=0 → after the boundary, each 4-cycle slot shows 1 cycle `AN`=FF, then 3 cycles `AN`=~(1<<i) with `seg` = decode(i). Digit 0 shows 40 and digit 7 shows 78.
- **Atomic update.** Mid-frame, load `digits`=32'hFFFFFFFF → `pending`=1 and the current frame still shows 0..7. Digit 0 of the next frame shows 0E and `pending` returns to 0.
- **Blanking and dp.** `digit_en`=8'b11111101, `dp_in`=8'b00000110 → in digit 1's slot `AN`=FF, `seg`=7F, `DP`=1. In digit 2's display phase, `DP`=0.
- **Double load.** Load A and then B within one frame → only B is ever displayed.
- **Load on boundary cycle.** Assert `load` on the boundary cycle → the new data is shown at digit 0 of the very next slot and `pending` stays 0.

Source files
------------

// File: rtl/seg7_scan_if.sv
// Bus between a display producer and the seven-segment scan driver:
// frame contents in, pin-level segment/anode drive and status out.
interface seg7_scan_if #(
    parameter int unsigned N_DIGITS = 8
);
    logic [4*N_DIGITS-1:0] digits;
    logic [N_DIGITS-1:0]   dp_in;
    logic [N_DIGITS-1:0]   digit_en;
    logic                  load;
    logic [6:0]            seg;
    logic                  DP;
    logic [N_DIGITS-1:0]   AN;
    logic                  frame_start;
    logic                  pending;

    modport master (
        output digits, dp_in, digit_en, load,
        input  seg, DP, AN, frame_start, pending
    );

    modport slave (
        input  digits, dp_in, digit_en, load,
        output seg, DP, AN, frame_start, pending
    );
endinterface

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed common-anode seven-segment driver with per-slot blanking
// and double-buffered contents that switch only at frame boundaries.
module seg7_scan_driver #(
    parameter int unsigned N_DIGITS     = 8,
    parameter int unsigned REFRESH_DIV  = 100000,
    parameter int unsigned BLANK_CYCLES = 1000
) (
    input  logic          clk,
    input  logic          rst,
    seg7_scan_if.slave    bus
);
    localparam int unsigned CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int unsigned IDX_W = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(REFRESH_DIV - 1);
    localparam logic [CNT_W-1:0] CNT_BLANK = CNT_W'(BLANK_CYCLES);
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(N_DIGITS - 1);

    logic [CNT_W-1:0]         cnt;
    logic [IDX_W-1:0]         idx;
    logic [N_DIGITS-1:0][3:0] pend_digits, disp_digits;
    logic [N_DIGITS-1:0]      pend_dp, pend_en, disp_dp, disp_en;
    logic                     pending;
    logic                     slot_end, boundary, show;
    logic [6:0]               seg_d;
    logic                     dp_d;
    logic [N_DIGITS-1:0]      an_d;

    function automatic logic [6:0] decode7(input logic [3:0] v);
        case (v)
            4'h0: decode7 = 7'h40;  4'h1: decode7 = 7'h79;
            4'h2: decode7 = 7'h24;  4'h3: decode7 = 7'h30;
            4'h4: decode7 = 7'h19;  4'h5: decode7 = 7'h12;
            4'h6: decode7 = 7'h02;  4'h7: decode7 = 7'h78;
            4'h8: decode7 = 7'h00;  4'h9: decode7 = 7'h10;
            4'hA: decode7 = 7'h08;  4'hB: decode7 = 7'h03;
            4'hC: decode7 = 7'h46;  4'hD: decode7 = 7'h21;
            4'hE: decode7 = 7'h06;  4'hF: decode7 = 7'h0E;
        endcase
    endfunction

    assign slot_end    = (cnt == CNT_LAST);
    assign boundary    = slot_end && (idx == IDX_LAST);
    assign bus.pending = pending;

    // Slot counter and scan index
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
            idx <= '0;
        end else if (slot_end) begin
            cnt <= '0;
            idx <= (idx == IDX_LAST) ? '0 : idx + IDX_W'(1);
        end else begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    // Pending/display banks; a load on the boundary bypasses the pending bank
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend_digits <= '0;
            pend_dp     <= '0;
            pend_en     <= '0;
            disp_digits <= '0;
            disp_dp     <= '0;
            disp_en     <= '0;
            pending     <= 1'b0;
        end else begin
            if (bus.load) begin
                pend_digits <= bus.digits;
                pend_dp     <= bus.dp_in;
                pend_en     <= bus.digit_en;
            end
            if (boundary) begin
                pending <= 1'b0;
                if (bus.load) begin
                    disp_digits <= bus.digits;
                    disp_dp     <= bus.dp_in;
                    disp_en     <= bus.digit_en;
                end else if (pending) begin
                    disp_digits <= pend_digits;
                    disp_dp     <= pend_dp;
                    disp_en     <= pend_en;
                end
            end else if (bus.load) begin
                pending <= 1'b1;
            end
        end
    end

    // Next pin values: dark during blanking or for a disabled digit
    always_comb begin
        an_d  = '1;
        seg_d = 7'h7F;
        dp_d  = 1'b1;
        show  = (cnt >= CNT_BLANK) && disp_en[idx];
        if (show) begin
            an_d[idx] = 1'b0;
            seg_d     = decode7(disp_digits[idx]);
            dp_d      = ~disp_dp[idx];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.AN          <= '1;
            bus.seg         <= 7'h7F;
            bus.DP          <= 1'b1;
            bus.frame_start <= 1'b0;
        end else begin
            bus.AN          <= an_d;
            bus.seg         <= seg_d;
            bus.DP          <= dp_d;
            bus.frame_start <= boundary;
        end
    end
endmodule

// File: tb/tb_seg7_scan_driver.sv
// Directed bench for seg7_scan_driver with 8 digits, 4-cycle slots, 1 blank cycle.
module tb_seg7_scan_driver;
    localparam int unsigned N  = 8;
    localparam int unsigned RD = 4;
    localparam int unsigned BL = 1;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    seg7_scan_if #(.N_DIGITS(N)) bus ();
    seg7_scan_driver #(.N_DIGITS(N), .REFRESH_DIV(RD), .BLANK_CYCLES(BL)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    bit exp_pend = 1'b0;

    logic [6:0] dec [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                             7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h cyc=%0d", tag, got, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic drive(input logic [31:0] d, input logic [7:0] dp, input logic [7:0] en);
        bus.digits   = d;
        bus.dp_in    = dp;
        bus.digit_en = en;
    endtask

    // Checks every cycle of one frame (cyc must be a multiple of 32 on entry),
    // optionally pulsing load at frame-relative cycles la and lb.
    task automatic check_frame(input logic [31:0] d, input logic [7:0] dp, input logic [7:0] en,
                               input string tag,
                               input int la, input logic [31:0] la_d, input logic [7:0] la_dp,
                               input logic [7:0] la_en,
                               input int lb, input logic [31:0] lb_d, input logic [7:0] lb_dp,
                               input logic [7:0] lb_en);
        for (int j = 0; j < 32; j++) begin
            bit         ld, bnd, lit;
            int         prev, i, ph;
            logic [7:0] exp_an;
            logic [6:0] exp_seg;
            logic [3:0] nib;
            ld  = (j == la) || (j == lb);
            bnd = (cyc % 32 == 31);
            if (j == la) drive(la_d, la_dp, la_en);
            else if (j == lb) drive(lb_d, lb_dp, lb_en);
            bus.load = ld;
            tick();
            bus.load = 1'b0;
            if (ld) exp_pend = !bnd;
            else if (bnd) exp_pend = 1'b0;
            prev   = cyc - 1;
            i      = (prev % 32) / 4;
            ph     = prev % 4;
            lit    = (ph != 0) && en[i];
            nib    = d[4*i +: 4];
            exp_an = 8'hFF;
            if (lit) exp_an[i] = 1'b0;
            exp_seg = lit ? dec[nib] : 7'h7F;
            check($sformatf("%s AN", tag), 32'(bus.AN), 32'(exp_an));
            check($sformatf("%s seg", tag), 32'(bus.seg), 32'(exp_seg));
            check($sformatf("%s DP", tag), 32'(bus.DP), 32'(!(lit && dp[i])));
            check($sformatf("%s frame_start", tag), 32'(bus.frame_start), 32'(cyc % 32 == 0));
            check($sformatf("%s pending", tag), 32'(bus.pending), 32'(exp_pend));
        end
    endtask

    task automatic check_dark(input string tag);
        check($sformatf("%s AN", tag), 32'(bus.AN), 32'hFF);
        check($sformatf("%s seg", tag), 32'(bus.seg), 32'h7F);
        check($sformatf("%s DP", tag), 32'(bus.DP), 32'h1);
        check($sformatf("%s pending", tag), 32'(bus.pending), 32'h0);
        check($sformatf("%s frame_start", tag), 32'(bus.frame_start), 32'h0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog timeout cyc=%0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        rst      = 1'b1;
        bus.load = 1'b0;
        drive(32'h0, 8'h0, 8'h0);
        repeat (2) @(posedge clk);
        #1;
        check_dark("reset");
        @(negedge clk);
        rst      = 1'b0;
        cyc      = 0;
        exp_pend = 1'b0;

        check_frame(32'h0, 8'h00, 8'h00, "boot",
                    5, 32'h76543210, 8'h00, 8'hFF, -1, 32'h0, 8'h0, 8'h0);
        check_frame(32'h76543210, 8'h00, 8'hFF, "scan",
                    10, 32'hFFFFFFFF, 8'h00, 8'hFF, -1, 32'h0, 8'h0, 8'h0);
        check_frame(32'hFFFFFFFF, 8'h00, 8'hFF, "atomic",
                    3, 32'h76543210, 8'h06, 8'hFD, -1, 32'h0, 8'h0, 8'h0);
        check_frame(32'h76543210, 8'h06, 8'hFD, "blankdp",
                    2, 32'h11111111, 8'h00, 8'hFF, 20, 32'hABCDEF98, 8'h81, 8'hFF);
        check_frame(32'hABCDEF98, 8'h81, 8'hFF, "dblload",
                    31, 32'h0123CDEF, 8'hF0, 8'h0F, -1, 32'h0, 8'h0, 8'h0);
        check_frame(32'h0123CDEF, 8'hF0, 8'h0F, "bndload",
                    -1, 32'h0, 8'h0, 8'h0, -1, 32'h0, 8'h0, 8'h0);

        // Mid-slot reset with a load outstanding
        tick();
        tick();
        check("prerst AN", 32'(bus.AN), 32'hFE);
        check("prerst seg", 32'(bus.seg), 32'h0E);
        drive(32'h88888888, 8'hFF, 8'hFF);
        bus.load = 1'b1;
        tick();
        bus.load = 1'b0;
        check("prerst pending", 32'(bus.pending), 32'h1);
        #2;
        rst = 1'b1;
        #1;
        check_dark("midrst");
        repeat (3) @(posedge clk);
        #1;
        check_dark("midrst hold");
        @(negedge clk);
        rst      = 1'b0;
        cyc      = 0;
        exp_pend = 1'b0;
        check_frame(32'h0, 8'h00, 8'h00, "postrst",
                    -1, 32'h0, 8'h0, 8'h0, -1, 32'h0, 8'h0, 8'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
